apb_slave_regfile: RTL and testbench
====================================

Name: apb_slave_regfile

Overview:
- APB3 completer (responder) for the bridge's APB initiator: decodes one slave select, runs the SETUP/ACCESS handshake with programmable wait states, and returns Prdata/Pready/Pslverr.
- Backs a small register file: one read-only ID word plus NREG-1 read/write control words, exported flat to the peripheral logic.
- Instantiated once per slave slot, driven by one psel_sN line of the bridge.

Parameters:
- NREG, 8, total 32-bit words (2..16); word 0 = ID, words 1..NREG-1 = RW.
- WAIT_CYCLES, 0, Pready-low cycles inserted in ACCESS (0..15).
- ID_VALUE, 32'hA5B0_0001, constant returned by word 0.

Ports:
- pclk  in  1  APB clock, rising edge.
- preset  in  1  synchronous, active-high reset.
- Psel  in  1  slave select from bridge.
- Penable  in  1  ACCESS phase indicator.
- Pwrite  in  1  1 = write, 0 = read.
- Paddr  in  32  byte address; only [5:0] decoded.
- Pwdata  in  32  write data.
- Prdata  out  32  read data, valid when Pready=1.
- Pready  out  1  transfer completes this cycle.
- Pslverr  out  1  error response, valid when Pready=1.
- regs_out  out  32*NREG  flat image; word k at [32k+31:32k], word 0 = ID_VALUE.

Behaviour:
- Reset (preset=1 at pclk edge): state=IDLE, Prdata=0, Pready=0, Pslverr=0, wait counter=0, RW words=0. Applies mid-transfer; an in-flight write is dropped.
- FSM states:
  - IDLE: Psel&~Penable (SETUP) -> WAIT when WAIT_CYCLES>0, counter=WAIT_CYCLES; otherwise -> RESP. Address, direction and data are captured on the SETUP cycle.
  - WAIT: counter decrements each cycle; counter==1 -> RESP. Psel=0 -> IDLE (abort).
  - RESP: Pready=1 for exactly one cycle, then unconditionally -> IDLE. A SETUP presented in the following cycle is accepted from IDLE, so back-to-back transfers cost 2+WAIT_CYCLES cycles each.
- Pready is driven only from state==RESP, so it is registered and zero outside RESP.
- With WAIT_CYCLES=0, Pready=1 in the first ACCESS cycle (zero-wait APB).
- Decode uses the captured address.
- Error when any of these hold:
  - Paddr[1:0]!=0 (misaligned).
  - Word index Paddr[5:2]>=NREG.
  - Write to word 0 (ID is read-only).
- Read: Prdata/Pslverr are loaded on the edge entering RESP. Prdata = word contents, or 0 on error. Prdata returns to 0 on the edge leaving RESP.
- Write: commits on the RESP edge when Psel&Penable&Pwrite and no error; the register shows the new value on the next cycle. Error writes modify nothing.
- Pslverr is asserted only together with Pready.
- Protocol violations:
  - Penable=1 seen in IDLE: ignored, no response.
  - Psel dropped during WAIT: abort, no write, no Pready.
  - Psel or Penable low in RESP: write suppressed; FSM still -> IDLE.
- Counter width is 4 bits; WAIT_CYCLES>15 is illegal and is checked by an elaboration-time assertion.

Decomposition:
- Shared package apb_pkg:
  - FSM state encoding: ST_IDLE, ST_WAIT, ST_RESP (2 bits).
  - APB_AW=32, APB_DW=32.
  - Function word_index(addr).
- One sub-module, apb_wait_counter: load/decrement/expired.
- Register array and decode stay in the top module.

Test Plan:
- Reset, then WAIT_CYCLES=0, read 0x00 -> Pready=1 in the first ACCESS cycle, Prdata=32'hA5B0_0001, Pslverr=0.
- Write 32'hDEAD_BEEF to 0x08, then read 0x08 -> regs_out word 2 = DEAD_BEEF on the cycle after write RESP; read returns DEAD_BEEF, no error.
- WAIT_CYCLES=3, write 0x04 -> Pready low for 3 ACCESS cycles, high on the 4th; word 1 unchanged until that edge.
- Error cases:
  - Write 0x00 -> Pslverr=1 with Pready, word 0 still ID_VALUE.
  - Read 0x06 -> Pslverr=1, Prdata=0.
  - Read 0x20 with NREG=8 -> Pslverr=1, Prdata=0.
- Back-to-back write 0x0C then read 0x0C with no idle cycle -> second SETUP accepted in the cycle after the first RESP; read returns the written data.
- Abort and reset:
  - preset=1 during WAIT of a write to 0x10 -> Pready=0 next cycle, word 4=0.
  - Separately, Psel dropped in WAIT -> no Pready, no write.

Source files
------------

// File: rtl/apb_pkg.sv
// Shared definitions for the APB register-file completer.
//   - APB bus widths
//   - FSM state encoding of the completer handshake
//   - word_index(): byte address -> 32-bit word index
package apb_pkg;

  localparam int APB_AW = 32;
  localparam int APB_DW = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } apb_state_e;

  // Only bits [5:2] of the byte address select a word; [1:0] are checked
  // separately for alignment.
  function automatic logic [3:0] word_index(input logic [5:0] addr);
    return addr[5:2];
  endfunction

endpackage

// File: rtl/apb_wait_counter.sv
// Wait-state down-counter for the APB completer.
// Ports:
//   clk_i       clock, rising edge
//   rst_i       synchronous active-high reset (count -> 0)
//   load_i      load load_val_i into the counter
//   load_val_i  value to load (number of wait cycles)
//   dec_i       decrement by one (saturates at zero)
//   count_o     current count
//   expired_o   high while count == 1, i.e. the last wait cycle
module apb_wait_counter (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       load_i,
  input  logic [3:0] load_val_i,
  input  logic       dec_i,
  output logic [3:0] count_o,
  output logic       expired_o
);

  logic [3:0] count_q;
  logic [3:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (dec_i && (count_q != 4'd0)) begin
      count_d = count_q - 4'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= 4'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o   = count_q;
  assign expired_o = (count_q == 4'd1);

endmodule

// File: rtl/apb_slave_regfile.sv
// APB3 completer backed by a small register file.
// Word 0 is a read-only ID, words 1..NREG-1 are read/write control words,
// all exported flat on regs_out.
//
// Handshake (valid/ready): a transfer is requested by a SETUP cycle
// (Psel=1, Penable=0) followed by ACCESS cycles (Psel=1, Penable=1). The
// transfer completes in the single ACCESS cycle where Pready=1; Prdata and
// Pslverr are only meaningful in that cycle. Pready is a decoded register
// state, never a combinational function of the inputs.
//
// Ports:
//   pclk, preset          clock, synchronous active-high reset
//   Psel, Penable, Pwrite APB control from the bridge
//   Paddr, Pwdata         byte address (bits [5:0] decoded) and write data
//   Prdata, Pready,
//   Pslverr               APB response
//   regs_out              flat register image, word k at [32k+31:32k]
//   dbg_state_o           current handshake FSM state
module apb_slave_regfile
  import apb_pkg::*;
#(
  parameter int          NREG        = 8,
  parameter int          WAIT_CYCLES = 0,
  parameter logic [31:0] ID_VALUE    = 32'hA5B0_0001
) (
  input  logic                pclk,
  input  logic                preset,
  input  logic                Psel,
  input  logic                Penable,
  input  logic                Pwrite,
  input  logic [APB_AW-1:0]   Paddr,
  input  logic [APB_DW-1:0]   Pwdata,
  output logic [APB_DW-1:0]   Prdata,
  output logic                Pready,
  output logic                Pslverr,
  output logic [32*NREG-1:0]  regs_out,
  output apb_state_e          dbg_state_o
);

  if (WAIT_CYCLES < 0 || WAIT_CYCLES > 15) begin : g_bad_wait
    $error("apb_slave_regfile: WAIT_CYCLES must be in 0..15");
  end
  if (NREG < 2 || NREG > 16) begin : g_bad_nreg
    $error("apb_slave_regfile: NREG must be in 2..16");
  end

  apb_state_e  state_q, state_d;
  logic [5:0]  addr_q;
  logic        write_q;
  logic [31:0] wdata_q;
  logic [31:0] prdata_q;
  logic        err_q;
  logic [31:0] rw_q [1:NREG-1];

  logic        setup;
  logic        capture;
  logic        enter_resp;
  logic        commit;
  logic        cnt_load;
  logic        cnt_dec;
  logic        cnt_expired;
  logic [3:0]  cnt_value;

  logic [5:0]  dec_addr;
  logic        dec_wr;
  logic [3:0]  dec_idx;
  logic        dec_err;
  logic [31:0] rd_word;
  logic [3:0]  commit_idx;

  logic        unused_paddr;
  logic [3:0]  unused_cnt;
  assign unused_paddr = ^Paddr[APB_AW-1:6];
  assign unused_cnt   = cnt_value;

  assign setup = Psel & ~Penable;

  // With zero wait states RESP is entered straight from the SETUP edge, so
  // decode has to look at the live bus; otherwise it uses the captured copy.
  assign dec_addr = (state_q == ST_IDLE) ? Paddr[5:0] : addr_q;
  assign dec_wr   = (state_q == ST_IDLE) ? Pwrite     : write_q;
  assign dec_idx  = word_index(dec_addr);
  assign dec_err  = (dec_addr[1:0] != 2'b00) ||
                    (int'(dec_idx) >= NREG)   ||
                    (dec_wr && (dec_idx == 4'd0));

  always_comb begin
    rd_word = 32'd0;
    if (dec_idx == 4'd0) begin
      rd_word = ID_VALUE;
    end else begin
      for (int k = 1; k < NREG; k++) begin
        if (int'(dec_idx) == k) rd_word = rw_q[k];
      end
    end
  end

  apb_wait_counter u_wait_counter (
    .clk_i      (pclk),
    .rst_i      (preset),
    .load_i     (cnt_load),
    .load_val_i (4'(WAIT_CYCLES)),
    .dec_i      (cnt_dec),
    .count_o    (cnt_value),
    .expired_o  (cnt_expired)
  );

  always_comb begin
    state_d    = state_q;
    capture    = 1'b0;
    enter_resp = 1'b0;
    commit     = 1'b0;
    cnt_load   = 1'b0;
    cnt_dec    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (setup) begin
          capture = 1'b1;
          if (WAIT_CYCLES > 0) begin
            state_d  = ST_WAIT;
            cnt_load = 1'b1;
          end else begin
            state_d    = ST_RESP;
            enter_resp = 1'b1;
          end
        end
      end
      ST_WAIT: begin
        if (!Psel) begin
          state_d = ST_IDLE;
        end else if (cnt_expired) begin
          state_d    = ST_RESP;
          enter_resp = 1'b1;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
        // err_q already folds in the read-only check on word 0.
        commit  = Psel & Penable & write_q & ~err_q;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign commit_idx = word_index(addr_q);

  always_ff @(posedge pclk) begin
    if (preset) begin
      state_q  <= ST_IDLE;
      addr_q   <= 6'd0;
      write_q  <= 1'b0;
      wdata_q  <= 32'd0;
      prdata_q <= 32'd0;
      err_q    <= 1'b0;
      for (int k = 1; k < NREG; k++) rw_q[k] <= 32'd0;
    end else begin
      state_q <= state_d;
      if (capture) begin
        addr_q  <= Paddr[5:0];
        write_q <= Pwrite;
        wdata_q <= Pwdata;
      end
      if (enter_resp) begin
        prdata_q <= (dec_wr || dec_err) ? 32'd0 : rd_word;
        err_q    <= dec_err;
      end else if (state_q == ST_RESP) begin
        prdata_q <= 32'd0;
        err_q    <= 1'b0;
      end
      if (commit) begin
        for (int k = 1; k < NREG; k++) begin
          if (int'(commit_idx) == k) rw_q[k] <= wdata_q;
        end
      end
    end
  end

  assign Pready      = (state_q == ST_RESP);
  assign Pslverr     = err_q & (state_q == ST_RESP);
  assign Prdata      = prdata_q;
  assign dbg_state_o = state_q;

  always_comb begin
    regs_out        = '0;
    regs_out[31:0]  = ID_VALUE;
    for (int k = 1; k < NREG; k++) regs_out[32*k +: 32] = rw_q[k];
  end

endmodule

// File: tb/tb_apb_slave_regfile.sv
// Bench for apb_slave_regfile: one zero-wait instance (u_dut0) and one
// three-wait instance (u_dut1) share the bus; psel is steered by tgt.
module tb_apb_slave_regfile;
  import apb_pkg::*;

  localparam int          NREG = 8;
  localparam logic [31:0] ID   = 32'hA5B0_0001;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        preset  = 1'b1;
  logic        psel    = 1'b0;
  logic        penable = 1'b0;
  logic        pwrite  = 1'b0;
  logic [31:0] paddr   = 32'd0;
  logic [31:0] pwdata  = 32'd0;
  int          tgt     = 0;

  logic              psel0, psel1;
  logic [31:0]       prdata0, prdata1;
  logic              pready0, pready1, pslverr0, pslverr1;
  logic [32*NREG-1:0] regs0, regs1;
  apb_state_e        st0, st1;

  assign psel0 = psel & (tgt == 0);
  assign psel1 = psel & (tgt == 1);

  apb_slave_regfile #(.NREG(NREG), .WAIT_CYCLES(0), .ID_VALUE(ID)) u_dut0 (
    .pclk(clk), .preset(preset), .Psel(psel0), .Penable(penable),
    .Pwrite(pwrite), .Paddr(paddr), .Pwdata(pwdata), .Prdata(prdata0),
    .Pready(pready0), .Pslverr(pslverr0), .regs_out(regs0), .dbg_state_o(st0)
  );

  apb_slave_regfile #(.NREG(NREG), .WAIT_CYCLES(3), .ID_VALUE(ID)) u_dut1 (
    .pclk(clk), .preset(preset), .Psel(psel1), .Penable(penable),
    .Pwrite(pwrite), .Paddr(paddr), .Pwdata(pwdata), .Prdata(prdata1),
    .Pready(pready1), .Pslverr(pslverr1), .regs_out(regs1), .dbg_state_o(st1)
  );

  logic [31:0] cur_prdata;
  logic        cur_pready, cur_pslverr;
  assign cur_prdata  = (tgt == 1) ? prdata1  : prdata0;
  assign cur_pready  = (tgt == 1) ? pready1  : pready0;
  assign cur_pslverr = (tgt == 1) ? pslverr1 : pslverr0;

  int total = 0;
  int bad   = 0;

  // ---------------- reference model ----------------
  logic [31:0] mdl [2][NREG];
  logic [31:0] exp_q [$];

  function automatic void mdl_clear();
    for (int d = 0; d < 2; d++)
      for (int k = 0; k < NREG; k++) mdl[d][k] = 32'd0;
  endfunction

  function automatic logic exp_err(input logic [31:0] a, input logic wr);
    int idx;
    idx = int'(a[5:2]);
    return (a[1:0] != 2'b00) || (idx >= NREG) || (wr && idx == 0);
  endfunction

  function automatic logic [31:0] exp_rd(input int d, input logic [31:0] a);
    int idx;
    idx = int'(a[5:2]);
    if (exp_err(a, 1'b0)) return 32'd0;
    if (idx == 0) return ID;
    return mdl[d][idx];
  endfunction

  function automatic logic [31:0] word_of(input int d, input int k);
    return (d == 1) ? regs1[32*k +: 32] : regs0[32*k +: 32];
  endfunction

  // ---------------- drivers ----------------
  task automatic apb_idle();
    @(negedge clk);
    psel    = 1'b0;
    penable = 1'b0;
  endtask

  // One full transfer; returns at the negedge sample where Pready=1.
  task automatic apb_xfer(input logic [31:0] a, input logic wr,
                          input logic [31:0] wd, output logic [31:0] rd,
                          output logic er, output int waits,
                          output logic tmo, output logic err_early);
    @(negedge clk);
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = wd;
    @(negedge clk);
    penable = 1'b1;
    waits = 0; tmo = 1'b1; err_early = 1'b0; rd = 32'd0; er = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (i > 0) @(negedge clk);
      if (cur_pready) begin
        rd = cur_prdata; er = cur_pslverr; tmo = 1'b0;
        break;
      end
      if (cur_pslverr) err_early = 1'b1;
      waits++;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    preset = 1'b1; psel = 1'b0; penable = 1'b0;
    repeat (3) @(negedge clk);
    mdl_clear();
    total++; if (pready0 !== 1'b0 || pready1 !== 1'b0) begin bad++;
      $display("FAIL reset_pready got %b/%b want 0/0", pready0, pready1); end
    total++; if (pslverr0 !== 1'b0 || pslverr1 !== 1'b0) begin bad++;
      $display("FAIL reset_pslverr got %b/%b want 0/0", pslverr0, pslverr1); end
    total++; if (prdata0 !== 32'd0 || prdata1 !== 32'd0) begin bad++;
      $display("FAIL reset_prdata got %h/%h want 0", prdata0, prdata1); end
    total++; if (st0 !== ST_IDLE || st1 !== ST_IDLE) begin bad++;
      $display("FAIL reset_state got %0d/%0d want IDLE", st0, st1); end
    for (int d = 0; d < 2; d++)
      for (int k = 0; k < NREG; k++) begin
        total++;
        if (word_of(d, k) !== ((k == 0) ? ID : 32'd0)) begin bad++;
          $display("FAIL reset_word d%0d w%0d got %h", d, k, word_of(d, k)); end
      end
    preset = 1'b0;
  endtask

  task automatic test_zero_wait_read();
    logic [31:0] rd; logic er, tmo, ee; int w;
    tgt = 0;
    apb_xfer(32'h00, 1'b0, 32'd0, rd, er, w, tmo, ee);
    total++; if (tmo || w != 0) begin bad++;
      $display("FAIL zw_read_latency waits=%0d tmo=%b want 0", w, tmo); end
    total++; if (rd !== ID || er !== 1'b0) begin bad++;
      $display("FAIL zw_read_id got %h err=%b want %h err=0", rd, er, ID); end
    apb_idle();
  endtask

  task automatic test_write_read();
    logic [31:0] rd; logic er, tmo, ee; int w;
    tgt = 0;
    apb_xfer(32'h08, 1'b1, 32'hDEAD_BEEF, rd, er, w, tmo, ee);
    total++; if (tmo || er !== 1'b0 || word_of(0, 2) !== mdl[0][2]) begin bad++;
      $display("FAIL wr_before_commit err=%b word2=%h want %h", er, word_of(0, 2), mdl[0][2]); end
    mdl[0][2] = 32'hDEAD_BEEF;
    apb_idle();
    total++; if (word_of(0, 2) !== 32'hDEAD_BEEF) begin bad++;
      $display("FAIL wr_after_commit word2=%h want deadbeef", word_of(0, 2)); end
    apb_xfer(32'h08, 1'b0, 32'd0, rd, er, w, tmo, ee);
    total++; if (tmo || rd !== 32'hDEAD_BEEF || er !== 1'b0) begin bad++;
      $display("FAIL rd_back got %h err=%b want deadbeef", rd, er); end
    apb_idle();
  endtask

  task automatic test_wait_write();
    logic [31:0] rd, v; logic er, tmo, ee; int w;
    tgt = 1;
    v = $urandom;
    apb_xfer(32'h04, 1'b1, v, rd, er, w, tmo, ee);
    total++; if (tmo || w != 3) begin bad++;
      $display("FAIL wait_count waits=%0d tmo=%b want 3", w, tmo); end
    total++; if (word_of(1, 1) !== mdl[1][1] || er !== 1'b0 || ee) begin bad++;
      $display("FAIL wait_word_early word1=%h err=%b want %h", word_of(1, 1), er, mdl[1][1]); end
    mdl[1][1] = v;
    apb_idle();
    total++; if (word_of(1, 1) !== v) begin bad++;
      $display("FAIL wait_word_commit word1=%h want %h", word_of(1, 1), v); end
    tgt = 0;
  endtask

  task automatic test_errors();
    logic [31:0] rd; logic er, tmo, ee; int w;
    tgt = 0;
    apb_xfer(32'h00, 1'b1, 32'h1234_5678, rd, er, w, tmo, ee);
    total++; if (tmo || er !== 1'b1) begin bad++;
      $display("FAIL err_wr_id pslverr=%b want 1", er); end
    apb_idle();
    total++; if (word_of(0, 0) !== ID) begin bad++;
      $display("FAIL err_wr_id_word got %h want %h", word_of(0, 0), ID); end
    apb_xfer(32'h06, 1'b0, 32'd0, rd, er, w, tmo, ee);
    total++; if (tmo || er !== 1'b1 || rd !== 32'd0) begin bad++;
      $display("FAIL err_misalign err=%b rd=%h want 1/0", er, rd); end
    apb_idle();
    apb_xfer(32'h20, 1'b0, 32'd0, rd, er, w, tmo, ee);
    total++; if (tmo || er !== 1'b1 || rd !== 32'd0) begin bad++;
      $display("FAIL err_range err=%b rd=%h want 1/0", er, rd); end
    apb_idle();
    total++; if (pslverr0 !== 1'b0 || prdata0 !== 32'd0) begin bad++;
      $display("FAIL err_cleared err=%b rd=%h want 0/0", pslverr0, prdata0); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd, v; logic er, tmo, ee; int w;
    tgt = 0;
    v = $urandom;
    apb_xfer(32'h0C, 1'b1, v, rd, er, w, tmo, ee);
    mdl[0][3] = v;
    apb_xfer(32'h0C, 1'b0, 32'd0, rd, er, w, tmo, ee);
    total++; if (tmo || w != 0) begin bad++;
      $display("FAIL b2b_latency waits=%0d tmo=%b want 0", w, tmo); end
    total++; if (rd !== v || er !== 1'b0) begin bad++;
      $display("FAIL b2b_data got %h err=%b want %h", rd, er, v); end
    apb_idle();
  endtask

  task automatic test_reset_abort();
    logic seen;
    tgt = 1;
    @(negedge clk);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h10; pwdata = 32'hCAFE_F00D;
    @(negedge clk); penable = 1'b1;
    @(negedge clk); preset = 1'b1;
    @(negedge clk);
    mdl_clear();
    total++; if (pready1 !== 1'b0 || st1 !== ST_IDLE) begin bad++;
      $display("FAIL rst_abort_pready pready=%b state=%0d want 0/IDLE", pready1, st1); end
    preset = 1'b0; psel = 1'b0; penable = 1'b0;
    seen = 1'b0;
    repeat (6) begin @(negedge clk); if (pready1) seen = 1'b1; end
    total++; if (seen || word_of(1, 4) !== 32'd0) begin bad++;
      $display("FAIL rst_abort_word pready_seen=%b word4=%h want 0/0", seen, word_of(1, 4)); end
    tgt = 0;
  endtask

  task automatic test_abort_psel();
    logic [31:0] rd, v; logic er, tmo, ee, seen; int w;
    tgt = 1;
    v = $urandom;
    apb_xfer(32'h14, 1'b1, v, rd, er, w, tmo, ee);
    mdl[1][5] = v;
    apb_idle();
    @(negedge clk);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h14; pwdata = ~v;
    @(negedge clk); penable = 1'b1;
    @(negedge clk); psel = 1'b0; penable = 1'b0;
    seen = 1'b0;
    repeat (8) begin @(negedge clk); if (pready1) seen = 1'b1; end
    total++; if (seen) begin bad++;
      $display("FAIL abort_pready seen=%b want 0", seen); end
    total++; if (word_of(1, 5) !== v) begin bad++;
      $display("FAIL abort_word word5=%h want %h", word_of(1, 5), v); end
    // Penable high without a SETUP cycle must be ignored.
    @(negedge clk); psel = 1'b1; penable = 1'b1; pwrite = 1'b0; paddr = 32'h00;
    seen = 1'b0;
    repeat (6) begin @(negedge clk); if (pready1) seen = 1'b1; end
    total++; if (seen) begin bad++;
      $display("FAIL penable_in_idle seen=%b want 0", seen); end
    apb_idle();
    tgt = 0;
  endtask

  task automatic test_random();
    logic [31:0] rd, a, v, e; logic er, tmo, ee, wr; int w, idx;
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 2) == 0) begin
        apb_idle();
        tgt = int'($urandom_range(0, 1));
      end
      idx = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, NREG - 1))
                                         : int'($urandom_range(0, 15));
      a = {26'd0, 4'(idx), 2'b00};
      if ($urandom_range(0, 3) == 0) a[1:0] = 2'($urandom_range(1, 3));
      wr = 1'($urandom_range(0, 1));
      v  = $urandom;
      if (!wr) exp_q.push_back(exp_rd(tgt, a));
      apb_xfer(a, wr, v, rd, er, w, tmo, ee);
      total++; if (tmo || w != ((tgt == 1) ? 3 : 0) || ee) begin bad++;
        $display("FAIL rnd_timing n=%0d waits=%0d tmo=%b early_err=%b", n, w, tmo, ee); end
      total++; if (er !== exp_err(a, wr)) begin bad++;
        $display("FAIL rnd_err n=%0d addr=%h wr=%b got %b want %b", n, a, wr, er, exp_err(a, wr)); end
      if (!wr) begin
        e = exp_q.pop_front();
        total++; if (rd !== e) begin bad++;
          $display("FAIL rnd_rdata n=%0d addr=%h got %h want %h", n, a, rd, e); end
      end else if (!exp_err(a, wr)) begin
        mdl[tgt][idx] = v;
      end
    end
    apb_idle();
    for (int d = 0; d < 2; d++)
      for (int k = 1; k < NREG; k++) begin
        total++;
        if (word_of(d, k) !== mdl[d][k]) begin bad++;
          $display("FAIL rnd_image d%0d w%0d got %h want %h", d, k, word_of(d, k), mdl[d][k]); end
      end
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    mdl_clear();
    test_reset();
    test_zero_wait_read();
    test_write_read();
    test_wait_write();
    test_errors();
    test_back_to_back();
    test_reset_abort();
    test_abort_psel();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard stop in case a driver loop ever stalls.
  initial begin
    #400000;
    $display("FAIL global_timeout reached at %0t", $time);
    $fatal(1, "timeout");
  end

endmodule
